// File: rtl/maxpool_stage_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pool stage: FSM encoding and
// default geometry. The optional ReLU clamp is selected by the POOL_RELU_EN macro.
package maxpool_stage_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned MAP_W_DEF  = 14;
  localparam int unsigned MAP_CH_DEF = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    LAST = 3'd5,
    WR   = 3'd6,
    FIN  = 3'd7
  } state_t;

endpackage

// File: rtl/maxpool_stage_pool_addr_gen.sv
// Output-position counters (q fastest, then r, then c) and the source-tap and
// destination address arithmetic for the max-pool stage.
module pool_addr_gen
  import maxpool_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAP_W    = MAP_W_DEF,
  parameter int unsigned MAP_CH   = MAP_CH_DEF,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 1176
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              adv_i,
  input  logic [1:0]        tap_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              last_o
);

  localparam int unsigned HALF = MAP_W / 2;
  localparam int unsigned QW   = $clog2(HALF + 1);
  localparam int unsigned CW   = $clog2(MAP_CH + 1);

  logic [QW-1:0] q_q, q_d, r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          q_end_s, r_end_s, c_end_s;

  assign q_end_s = (q_q == QW'(HALF - 1));
  assign r_end_s = (r_q == QW'(HALF - 1));
  assign c_end_s = (c_q == CW'(MAP_CH - 1));
  assign last_o  = q_end_s & r_end_s & c_end_s;

  // Next position: wrap q into r into c exactly at the map and channel limits
  always_comb begin
    q_d = q_q;
    r_d = r_q;
    c_d = c_q;
    if (clear_i) begin
      q_d = '0;
      r_d = '0;
      c_d = '0;
    end else if (adv_i) begin
      if (!q_end_s) begin
        q_d = q_q + QW'(1);
      end else begin
        q_d = '0;
        if (!r_end_s) begin
          r_d = r_q + QW'(1);
        end else begin
          r_d = '0;
          if (c_end_s) begin
            c_d = '0;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign src_addr_o = ADDR_W'(SRC_BASE)
                    + ADDR_W'(c_q) * ADDR_W'(MAP_W * MAP_W)
                    + (ADDR_W'({r_q, 1'b0}) + ADDR_W'(tap_i[1])) * ADDR_W'(MAP_W)
                    + ADDR_W'({q_q, 1'b0}) + ADDR_W'(tap_i[0]);

  assign dst_addr_o = ADDR_W'(DST_BASE)
                    + ADDR_W'(c_q) * ADDR_W'(HALF * HALF)
                    + ADDR_W'(r_q) * ADDR_W'(HALF)
                    + ADDR_W'(q_q);

endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 max-pool over a BRAM-resident feature map, one output per six
// cycles. Define POOL_RELU_EN to clamp negative window maxima to zero.
module maxpool_stage
  import maxpool_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAP_W    = MAP_W_DEF,
  parameter int unsigned MAP_CH   = MAP_CH_DEF,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 1176
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_en,
  input  logic [DATA_W-1:0] src_dout,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_en,
  output logic              dst_we,
  output logic [DATA_W-1:0] dst_din
);

  state_t            state_q;
  logic              busy_q, done_q, src_en_q, dst_en_q, dst_we_q, last_q;
  logic [ADDR_W-1:0] src_addr_q, dst_addr_q;
  logic [DATA_W-1:0] dst_din_q, max_q, max_s, pool_s;
  logic [ADDR_W-1:0] src_addr_s, dst_addr_s;
  logic [1:0]        tap_s;
  logic              last_s;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Tap index of the read issued on entering the next state
  always_comb begin
    case (state_q)
      RD0:     tap_s = 2'd1;
      RD1:     tap_s = 2'd2;
      RD2:     tap_s = 2'd3;
      default: tap_s = 2'd0;
    endcase
  end

  // Window result including the final tap arriving in LAST
  always_comb begin
    max_s = smax(max_q, src_dout);
`ifdef POOL_RELU_EN
    if (max_s[DATA_W-1]) begin
      pool_s = '0;
    end else begin
      pool_s = max_s;
    end
`else
    pool_s = max_s;
`endif
  end

  pool_addr_gen #(
    .ADDR_W  (ADDR_W),
    .MAP_W   (MAP_W),
    .MAP_CH  (MAP_CH),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == IDLE),
    .adv_i     (state_q == LAST),
    .tap_i     (tap_s),
    .src_addr_o(src_addr_s),
    .dst_addr_o(dst_addr_s),
    .last_o    (last_s)
  );

  // Sequencer with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_en_q   <= 1'b0;
      dst_en_q   <= 1'b0;
      dst_we_q   <= 1'b0;
      last_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_din_q  <= '0;
      max_q      <= '0;
    end else begin
      src_en_q <= 1'b0;
      dst_en_q <= 1'b0;
      dst_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RD0;
            busy_q     <= 1'b1;
            src_en_q   <= 1'b1;
            src_addr_q <= src_addr_s;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RD0: begin
          state_q    <= RD1;
          src_en_q   <= 1'b1;
          src_addr_q <= src_addr_s;
        end
        RD1: begin
          state_q    <= RD2;
          src_en_q   <= 1'b1;
          src_addr_q <= src_addr_s;
          max_q      <= src_dout;
        end
        RD2: begin
          state_q    <= RD3;
          src_en_q   <= 1'b1;
          src_addr_q <= src_addr_s;
          max_q      <= smax(max_q, src_dout);
        end
        RD3: begin
          state_q <= LAST;
          max_q   <= smax(max_q, src_dout);
        end
        LAST: begin
          state_q    <= WR;
          dst_en_q   <= 1'b1;
          dst_we_q   <= 1'b1;
          dst_addr_q <= dst_addr_s;
          dst_din_q  <= pool_s;
          last_q     <= last_s;
        end
        WR: begin
          if (last_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q    <= RD0;
            src_en_q   <= 1'b1;
            src_addr_q <= src_addr_s;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign src_en   = src_en_q;
  assign src_addr = src_addr_q;
  assign dst_en   = dst_en_q;
  assign dst_we   = dst_we_q;
  assign dst_addr = dst_addr_q;
  assign dst_din  = dst_din_q;

endmodule
